// File: rtl/regfile_pkg.sv
// Shared constants for the LEGv8 register file: geometry, zero-register index
// and the write-counter ceiling.
package regfile_pkg;

    localparam int          REG_COUNT   = 32;
    localparam int          XZR_IDX     = 31;
    localparam int          DATA_W      = 64;
    localparam int          ADDR_W      = 5;
    localparam logic [15:0] WRCOUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: index decode, XZR forcing and, with
// REGFILE_BYPASS_EN defined, forwarding of the in-flight write data.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] regs [REG_COUNT-1],
    input  logic              byp_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data
);

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        data = '0;
        if (addr != ADDR_W'(XZR_IDX)) begin
            data = regs[addr];
        end
        // byp_en already excludes XZR and reset, so an index match is enough
        if (byp_en && (addr == wr_addr)) begin
            data = wr_data;
        end
    end
`else
    logic unused_byp;
    assign unused_byp = ^{byp_en, wr_addr, wr_data};

    always_comb begin
        data = '0;
        if (addr != ADDR_W'(XZR_IDX)) begin
            data = regs[addr];
        end
    end
`endif

endmodule

// File: rtl/register_file.sv
// 32 x 64-bit LEGv8 register file with XZR, a debug read port and a saturating
// write counter. Define REGFILE_BYPASS_EN to forward BusW onto BusA/BusB.
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int RD_DLY = 2
) (
    input  logic              Clk,
    input  logic              resetl,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [ADDR_W-1:0] RW,
    input  logic              RegWr,
    input  logic [DATA_W-1:0] BusW,
    output logic [DATA_W-1:0] BusA,
    output logic [DATA_W-1:0] BusB,
    input  logic [ADDR_W-1:0] DbgAddr,
    output logic [DATA_W-1:0] DbgData,
    output logic [15:0]       WrCount
);

    // Read delay is a simulation-timing figure only; the RTL reads settle in zero time.
    if (RD_DLY < 0) begin : g_rd_dly_negative
    end

    logic [DATA_W-1:0] regs [REG_COUNT-1];
    logic              wr_ok;
    logic              wr_commit;
    logic [15:0]       wr_count;

    // wr_ok stays low through the edge on which resetl is released, so a write
    // presented on that edge is dropped and the first commit is one edge later.
    assign wr_commit = wr_ok && RegWr && (RW != ADDR_W'(XZR_IDX));

    always_ff @(posedge Clk or negedge resetl) begin
        if (!resetl) begin
            wr_ok    <= 1'b0;
            wr_count <= '0;
            for (int i = 0; i < REG_COUNT - 1; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_ok <= 1'b1;
            if (wr_commit) begin
                regs[RW] <= BusW;
                if (wr_count != WRCOUNT_MAX) begin
                    wr_count <= wr_count + 16'd1;
                end
            end
        end
    end

    assign WrCount = wr_count;

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
        .addr    (RA),
        .regs    (regs),
        .byp_en  (wr_commit),
        .wr_addr (RW),
        .wr_data (BusW),
        .data    (BusA)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
        .addr    (RB),
        .regs    (regs),
        .byp_en  (wr_commit),
        .wr_addr (RW),
        .wr_data (BusW),
        .data    (BusB)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_dbg (
        .addr    (DbgAddr),
        .regs    (regs),
        .byp_en  (1'b0),
        .wr_addr (RW),
        .wr_data (BusW),
        .data    (DbgData)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, basic write/read, XZR, same-cycle
// hazard, write disable, mid-run reset, counter saturation and debug port.
module tb_register_file;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int RD_DLY = 2;

    logic              Clk;
    logic              resetl;
    logic [ADDR_W-1:0] RA, RB, RW, DbgAddr;
    logic              RegWr;
    logic [DATA_W-1:0] BusW;
    logic [DATA_W-1:0] BusA, BusB, DbgData;
    logic [15:0]       WrCount;

    int n_tests = 0;
    int n_fail  = 0;

    register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_DLY(RD_DLY)) dut (
        .Clk     (Clk),
        .resetl  (resetl),
        .RA      (RA),
        .RB      (RB),
        .RW      (RW),
        .RegWr   (RegWr),
        .BusW    (BusW),
        .BusA    (BusA),
        .BusB    (BusB),
        .DbgAddr (DbgAddr),
        .DbgData (DbgData),
        .WrCount (WrCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+3; commits one write on the edge in between.
    task automatic wr(input logic [ADDR_W-1:0] idx, input logic [DATA_W-1:0] val);
        RW    = idx;
        BusW  = val;
        RegWr = 1'b1;
        n_tests++;
        assert (!$isunknown(RegWr)) else begin
            n_fail++;
            $error("FAIL regwr_known: observed %b expected 0/1", RegWr);
        end
        @(posedge Clk);
        #3;
        RegWr = 1'b0;
    endtask

    logic [63:0] exp_hazard;

    initial begin
        resetl  = 1'b0;
        RA      = '0;
        RB      = '0;
        RW      = '0;
        DbgAddr = '0;
        RegWr   = 1'b0;
        BusW    = '0;
        repeat (2) @(posedge Clk);
        #3;

        // Reset held: every index reads zero even with a write presented
        RegWr = 1'b1;
        BusW  = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 32; i++) begin
            RA = ADDR_W'(i);
            RW = ADDR_W'(i);
            #1;
            chk($sformatf("rst_busa_%0d", i), BusA, 64'h0);
        end
        chk("rst_wrcount", {48'h0, WrCount}, 64'h0);
        RegWr = 1'b0;

        // Write presented on the edge where reset releases is dropped
        @(posedge Clk);
        #3;
        RegWr = 1'b1;
        RW    = 5'd1;
        BusW  = 64'h77;
        #6;
        resetl = 1'b1;
        @(posedge Clk);
        #3;
        RegWr   = 1'b0;
        DbgAddr = 5'd1;
        #1;
        chk("release_edge_dbg1", DbgData, 64'h0);
        chk("release_edge_cnt", {48'h0, WrCount}, 64'h0);

        // Basic write and dual read
        wr(5'd3, 64'h0123_4567_89AB_CDEF);
        RA = 5'd3;
        RB = 5'd3;
        #1;
        chk("basic_busa", BusA, 64'h0123_4567_89AB_CDEF);
        chk("basic_busb", BusB, 64'h0123_4567_89AB_CDEF);
        chk("basic_cnt", {48'h0, WrCount}, 64'd1);

        // XZR write discarded and uncounted
        wr(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        RA = 5'd31;
        #1;
        chk("xzr_busa", BusA, 64'h0);
        chk("xzr_cnt", {48'h0, WrCount}, 64'd1);

        // Same-cycle hazard on X7
        wr(5'd7, 64'd10);
`ifdef REGFILE_BYPASS_EN
        exp_hazard = 64'd20;
`else
        exp_hazard = 64'd10;
`endif
        RW      = 5'd7;
        BusW    = 64'd20;
        RegWr   = 1'b1;
        RA      = 5'd7;
        RB      = 5'd7;
        DbgAddr = 5'd7;
        #1;
        chk("hazard_pre_busa", BusA, exp_hazard);
        chk("hazard_pre_busb", BusB, exp_hazard);
        chk("hazard_pre_dbg", DbgData, 64'd10);
        @(posedge Clk);
        #3;
        RegWr = 1'b0;
        #1;
        chk("hazard_post_busa", BusA, 64'd20);
        chk("hazard_post_busb", BusB, 64'd20);
        chk("hazard_cnt", {48'h0, WrCount}, 64'd3);

        // Write disable over four edges
        RegWr = 1'b0;
        RW    = 5'd9;
        BusW  = 64'h55;
        repeat (4) @(posedge Clk);
        #3;
        RA = 5'd9;
        #1;
        chk("wrdis_busa", BusA, 64'h0);
        chk("wrdis_cnt", {48'h0, WrCount}, 64'd3);

        // Asynchronous reset mid-cycle, with a write pending at the next edge
        wr(5'd5, 64'hDEAD);
        RA = 5'd5;
        #1;
        chk("pre_rst_busa", BusA, 64'hDEAD);
        RegWr   = 1'b1;
        RW      = 5'd6;
        BusW    = 64'h66;
        DbgAddr = 5'd5;
        resetl  = 1'b0;
        #(RD_DLY);
        chk("async_rst_busa", BusA, 64'h0);
        chk("async_rst_dbg", DbgData, 64'h0);
        chk("async_rst_cnt", {48'h0, WrCount}, 64'h0);
        @(posedge Clk);
        #3;
        RegWr = 1'b0;
        #2;
        resetl = 1'b1;
        @(posedge Clk);
        #3;
        DbgAddr = 5'd6;
        RA      = 5'd3;
        #1;
        chk("lost_write_dbg6", DbgData, 64'h0);
        chk("cleared_x3", BusA, 64'h0);

        // Saturation: 65540 writes, RW = i mod 31, BusW = i
        RegWr = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            RW   = ADDR_W'(i % 31);
            BusW = 64'(i);
            @(posedge Clk);
            #1;
            if (i == 65534) begin
                chk("sat_reach", {48'h0, WrCount}, 64'hFFFF);
            end
        end
        RegWr = 1'b0;
        #2;
        chk("sat_hold", {48'h0, WrCount}, 64'hFFFF);
        DbgAddr = 5'd5;
        #1;
        chk("dbg_last_write", DbgData, 64'h1_0003);
        DbgAddr = 5'd31;
        #1;
        chk("dbg_xzr", DbgData, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
